// File: rtl/alu_pipelined.sv
// -----------------------------------------------------------------------------
// alu_pipelined
//   Two-stage valid/ready ALU. Stage 1 captures {ctrl, x, y} on the input
//   handshake. Stage 2 holds the computed result and its flags until the
//   consumer takes them. Results leave in acceptance order, and no result is
//   lost or repeated whatever the out_ready pattern.
//
// Configuration macro: ALU_MUL_EN
//   Defined   : opcode 4'b1101 runs an unsigned shift-add multiply in stage 1.
//               It takes WIDTH cycles, and in_ready is low while it iterates.
//   Undefined : opcode 4'b1101 returns 0 with all flags clear. No multiply
//               logic is built.
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : operation offered
//   in_ready   : operation accepted when in_valid && in_ready (combinational)
//   ctrl[3:0]  : opcode
//   x, y       : signed operands, WIDTH bits
//   out_valid  : result held on out and the flags
//   out_ready  : result consumed when out_valid && out_ready
//   out        : result, WIDTH bits
//   out_carry  : carry flag (add, sub, multiply only)
//   out_ovf    : signed-overflow flag (add and sub only)
//   out_zero   : high when out == 0
// -----------------------------------------------------------------------------
module alu_pipelined #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_ASR  = 4'b1000;
    localparam logic [3:0] OP_ASR1 = 4'b1001;
    localparam logic [3:0] OP_ROL  = 4'b1010;
    localparam logic [3:0] OP_ROR  = 4'b1011;
    localparam logic [3:0] OP_EQ   = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_ctrl_q,  s1_ctrl_d;
    logic [WIDTH-1:0] s1_x_q,     s1_x_d;
    logic [WIDTH-1:0] s1_y_q,     s1_y_d;

    // Stage 2 registers, which drive the outputs directly
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             carry_q,     carry_d;
    logic             ovf_q,       ovf_d;
    logic             zero_q,      zero_d;

    logic             s1_iter_s;
    logic             s2_load_s;
    logic             s1_load_s;
    logic [WIDTH-1:0] res_out_s;
    logic             res_carry_s;
    logic             res_ovf_s;
    logic [WIDTH:0]   sum_ext_s;
    logic [WIDTH:0]   diff_ext_s;

`ifdef ALU_MUL_EN
    logic [SHW-1:0]     mul_cnt_q,    mul_cnt_d;
    logic               mul_done_q,   mul_done_d;
    logic [2*WIDTH-1:0] mul_acc_q,    mul_acc_d;
    logic [2*WIDTH-1:0] mul_mcand_q,  mul_mcand_d;
    logic [WIDTH-1:0]   mul_mplier_q, mul_mplier_d;
`endif

    // Handshake: stage 2 takes stage 1 when the slot is free or being drained
    always_comb begin
`ifdef ALU_MUL_EN
        s1_iter_s = s1_valid_q && (s1_ctrl_q == OP_MUL) && !mul_done_q;
`else
        s1_iter_s = 1'b0;
`endif
        s2_load_s = s1_valid_q && !s1_iter_s && (!out_valid_q || out_ready);
        s1_load_s = !s1_valid_q || s2_load_s;
        in_ready  = s1_load_s;
    end

    // Stage 1 next state: capture the operands on the input handshake
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        if (s1_load_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_ctrl_d = ctrl;
                s1_x_d    = x;
                s1_y_d    = y;
            end else begin
                s1_ctrl_d = s1_ctrl_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier next state: one shift-add step per cycle while iterating
    always_comb begin
        mul_cnt_d    = mul_cnt_q;
        mul_done_d   = mul_done_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        if (s1_load_s && in_valid) begin
            mul_cnt_d    = {SHW{1'b0}};
            mul_done_d   = 1'b0;
            mul_acc_d    = {(2*WIDTH){1'b0}};
            mul_mcand_d  = {{WIDTH{1'b0}}, x};
            mul_mplier_d = y;
        end else if (s1_iter_s) begin
            mul_acc_d    = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : {(2*WIDTH){1'b0}});
            mul_mcand_d  = mul_mcand_q << 1;
            mul_mplier_d = mul_mplier_q >> 1;
            mul_cnt_d    = mul_cnt_q + {{(SHW-1){1'b0}}, 1'b1};
            // The last step (count WIDTH-1) marks the product as ready
            mul_done_d   = (mul_cnt_q == SHW'(WIDTH - 1));
        end else begin
            mul_done_d   = mul_done_q;
        end
    end

    // Multiplier registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_cnt_q    <= {SHW{1'b0}};
            mul_done_q   <= 1'b0;
            mul_acc_q    <= {(2*WIDTH){1'b0}};
            mul_mcand_q  <= {(2*WIDTH){1'b0}};
            mul_mplier_q <= {WIDTH{1'b0}};
        end else begin
            mul_cnt_q    <= mul_cnt_d;
            mul_done_q   <= mul_done_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
        end
    end
`endif

    // Result datapath, evaluated from the stage 1 contents
    always_comb begin
        sum_ext_s   = {s1_x_q[WIDTH-1], s1_x_q} + {s1_y_q[WIDTH-1], s1_y_q};
        diff_ext_s  = {s1_x_q[WIDTH-1], s1_x_q} - {s1_y_q[WIDTH-1], s1_y_q};
        res_out_s   = {WIDTH{1'b0}};
        res_carry_s = 1'b0;
        res_ovf_s   = 1'b0;
        case (s1_ctrl_q)
            // With sign-extended operands, overflow shows as the top two bits differing
            OP_ADD: begin
                res_out_s   = sum_ext_s[WIDTH-1:0];
                res_carry_s = sum_ext_s[WIDTH];
                res_ovf_s   = sum_ext_s[WIDTH] ^ sum_ext_s[WIDTH-1];
            end
            OP_SUB: begin
                res_out_s   = diff_ext_s[WIDTH-1:0];
                res_carry_s = diff_ext_s[WIDTH];
                res_ovf_s   = diff_ext_s[WIDTH] ^ diff_ext_s[WIDTH-1];
            end
            OP_AND:  res_out_s = s1_x_q & s1_y_q;
            OP_OR:   res_out_s = s1_x_q | s1_y_q;
            OP_NOT:  res_out_s = ~s1_x_q;
            OP_XOR:  res_out_s = s1_x_q ^ s1_y_q;
            OP_NOR:  res_out_s = ~(s1_x_q | s1_y_q);
            OP_SHL:  res_out_s = s1_y_q << s1_x_q[SHW-1:0];
            OP_ASR:  res_out_s = $signed(s1_y_q) >>> s1_x_q[SHW-1:0];
            OP_ASR1: res_out_s = {s1_x_q[WIDTH-1], s1_x_q[WIDTH-1:1]};
            OP_ROL:  res_out_s = {s1_x_q[WIDTH-2:0], s1_x_q[WIDTH-1]};
            OP_ROR:  res_out_s = {s1_x_q[0], s1_x_q[WIDTH-1:1]};
            OP_EQ:   res_out_s = {{(WIDTH-1){1'b0}}, (s1_x_q == s1_y_q)};
`ifdef ALU_MUL_EN
            OP_MUL: begin
                res_out_s   = mul_acc_q[WIDTH-1:0];
                res_carry_s = |mul_acc_q[2*WIDTH-1:WIDTH];
            end
`else
            OP_MUL:  res_out_s = {WIDTH{1'b0}};
`endif
            default: res_out_s = {WIDTH{1'b0}};
        endcase
    end

    // Stage 2 next state: load a new result, or hold it until consumed
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (s2_load_s) begin
            out_valid_d = 1'b1;
            out_d       = res_out_s;
            carry_d     = res_carry_s;
            ovf_d       = res_ovf_s;
            zero_d      = (res_out_s == {WIDTH{1'b0}});
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ctrl_q   <= 4'b0000;
            s1_x_q      <= {WIDTH{1'b0}};
            s1_y_q      <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            out_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_alu_pipelined.sv
module tb_alu_pipelined;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ctrl;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_carry;
    logic         out_ovf;
    logic         out_zero;

    alu_pipelined #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    bit          acc_last;

    // Reference: {out[7:0], carry, ovf, zero}
    function automatic logic [10:0] model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        int         sa;
        int         sb;
        int         r;
        int         p;
        logic [7:0] o;
        logic       cy;
        logic       ov;
        sa = $signed(a);
        sb = $signed(b);
        r  = 0;
        p  = 0;
        o  = 8'h00;
        cy = 1'b0;
        ov = 1'b0;
        case (c)
            4'h0: begin r = sa + sb; o = r[7:0]; cy = r[8]; ov = (r > 127) || (r < -128); end
            4'h1: begin r = sa - sb; o = r[7:0]; cy = r[8]; ov = (r > 127) || (r < -128); end
            4'h2: o = a & b;
            4'h3: o = a | b;
            4'h4: o = ~a;
            4'h5: o = a ^ b;
            4'h6: o = ~(a | b);
            4'h7: o = b << a[2:0];
            4'h8: begin r = sb >>> a[2:0]; o = r[7:0]; end
            4'h9: begin r = sa / 2; if (sa < 0 && (sa % 2) != 0) r = r - 1; o = r[7:0]; end
            4'hA: o = (a << 1) | (a >> 7);
            4'hB: o = (a >> 1) | (a << 7);
            4'hC: o = (a == b) ? 8'h01 : 8'h00;
`ifdef ALU_MUL_EN
            4'hD: begin p = int'(a) * int'(b); o = p[7:0]; cy = (p > 255); end
`endif
            default: o = 8'h00;
        endcase
        return {o, cy, ov, (o == 8'h00)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: called at the negedge with inputs already driven
    task automatic step();
        logic [3:0] c;
        logic [7:0] a;
        logic [7:0] b;
        bit         acc;
        bit         cons;
        #1;
        acc  = in_valid && in_ready;
        cons = out_valid && out_ready;
        c = ctrl;
        a = x;
        b = y;
        if (out_valid) begin
            chk("result_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("result", 32'({out, out_carry, out_ovf, out_zero}), 32'(exp_q[0]));
                if (cons) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        if (acc) exp_q.push_back(model(c, a, b));
        acc_last = acc;
        @(negedge clk);
    endtask

    task automatic single_op(input string tag, input logic [3:0] c, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] eo, input logic [2:0] ef,
                             input int lat);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ctrl = c;
        x    = a;
        y    = b;
        step();
        chk({tag, "_accept"}, 32'(acc_last), 32'd1);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_out"}, 32'(out), 32'(eo));
        chk({tag, "_flags"}, 32'({out_carry, out_ovf, out_zero}), 32'(ef));
        step();
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    logic [3:0] bb_c [4] = '{4'h1, 4'hC, 4'h7, 4'h8};
    logic [7:0] bb_x [4] = '{8'h00, 8'h5A, 8'h03, 8'h01};
    logic [7:0] bb_y [4] = '{8'h01, 8'h5A, 8'h81, 8'h80};

    initial begin
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ctrl      = 4'h0;
        x         = 8'h00;
        y         = 8'h00;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_flags", 32'({out_carry, out_ovf, out_zero}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        single_op("add",  4'h0, 8'h7F, 8'h01, 8'h80, 3'b010, 2);
        single_op("sub",  4'h1, 8'h00, 8'h01, 8'hFF, 3'b100, 2);
        single_op("eq",   4'hC, 8'h5A, 8'h5A, 8'h01, 3'b000, 2);
        single_op("shl",  4'h7, 8'h03, 8'h81, 8'h08, 3'b000, 2);
        single_op("asr",  4'h8, 8'h01, 8'h80, 8'hC0, 3'b000, 2);
        single_op("rotl", 4'hA, 8'h81, 8'h00, 8'h03, 3'b000, 2);
`ifdef ALU_MUL_EN
        single_op("mul",  4'hD, 8'h10, 8'h14, 8'h40, 3'b100, 10);
`else
        single_op("mul",  4'hD, 8'h10, 8'h14, 8'h00, 3'b001, 2);
`endif

        // Back-to-back with the consumer stalled for five cycles
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            ctrl = bb_c[k];
            x    = bb_x[k];
            y    = bb_y[k];
            step();
            if (acc_last) k++;
        end
        chk("bb_accepted_while_stalled", 32'(k), 32'd2);
        chk("bb_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && k < 4; i++) begin
            in_valid = 1'b1;
            ctrl = bb_c[k];
            x    = bb_x[k];
            y    = bb_y[k];
            step();
            if (acc_last) k++;
        end
        chk("bb_all_accepted", 32'(k), 32'd4);
        drain();

        // Reset pulse in the middle of a multiply
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ctrl = 4'hD;
        x    = 8'h10;
        y    = 8'h14;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #2;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
        single_op("add_after_rst", 4'h0, 8'h12, 8'h34, 8'h46, 3'b000, 2);

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            ctrl = 4'($urandom_range(0, 15));
            x    = 8'($urandom_range(0, 255));
            y    = 8'($urandom_range(0, 255));
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
